prime_stream_gen: RTL

PRIME_STREAM_GEN -- requirements
Module: prime_stream_gen

---
 rtl/prime_pkg.sv | 15 +
 rtl/divmod_seq.sv | 69 ++++++
 rtl/prime_stream_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/prime_pkg.sv
// Shared definitions for the prime stream generator: FSM encoding and default data width.
package prime_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    CAND,
    DIV_START,
    DIV_WAIT,
    EMIT,
    FIN
  } state_t;

endpackage

// File: rtl/divmod_seq.sv
// Restoring divider: one quotient bit per cycle, WIDTH+1 cycles from start to the done pulse.
module divmod_seq
  import prime_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] sub;
  logic             fits;
  logic [WIDTH-1:0] new_rem;

  // the partial remainder never reaches 2*divisor, so a WIDTH-bit subtract is exact when it fits
  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign fits    = (partial >= {1'b0, dvsr_q});
  assign sub     = partial[WIDTH-1:0] - dvsr_q;
  assign new_rem = fits ? sub : partial[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo_q  <= dividend;
        rem_q  <= '0;
        dvsr_q <= divisor;
        cnt_q  <= CW'(WIDTH);
        run_q  <= 1'b1;
      end else if (run_q) begin
        quo_q <= {quo_q[WIDTH-2:0], fits};
        rem_q <= new_rem;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign busy      = run_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/prime_stream_gen.sv
// Streams every prime in [2, limit] in ascending order using trial division by odd divisors.
//
// state     | meaning
// IDLE      | waiting for start; limit latched on acceptance
// CAND      | range/parity screening of the current candidate
// DIV_START | stop if divisor^2 > candidate, else launch candidate/divisor
// DIV_WAIT  | waiting for the divider; zero remainder marks a composite
// EMIT      | candidate presented on the out stream until transferred
// FIN       | one-cycle done pulse, then back to IDLE
module prime_stream_gen
  import prime_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             abort,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_prime,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  state_t state, state_nx;

  logic [WIDTH-1:0]   lim_q, lim_nx;
  logic [WIDTH-1:0]   cand_q, cand_nx;
  logic [WIDTH-1:0]   div_q, div_nx;
  logic [WIDTH:0]     cand_inc;
  logic [2*WIDTH-1:0] div_sq;
  state_t             adv_state;
  logic [WIDTH-1:0]   adv_cand;

  logic             div_start;
  logic             div_done;
  logic             div_busy_unused;
  logic [WIDTH-1:0] div_quot_unused;
  logic [WIDTH-1:0] div_rem;

  divmod_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (cand_q),
    .divisor   (div_q),
    .done      (div_done),
    .busy      (div_busy_unused),
    .quotient  (div_quot_unused),
    .remainder (div_rem)
  );

  // a carry out of the candidate ends the run instead of wrapping to small values
  assign cand_inc  = {1'b0, cand_q} + ((cand_q == WIDTH'(2)) ? (WIDTH+1)'(1) : (WIDTH+1)'(2));
  assign adv_state = cand_inc[WIDTH] ? FIN : CAND;
  assign adv_cand  = cand_inc[WIDTH] ? cand_q : cand_inc[WIDTH-1:0];
  assign div_sq    = (2*WIDTH)'(div_q) * (2*WIDTH)'(div_q);

  always_comb begin
    state_nx  = state;
    lim_nx    = lim_q;
    cand_nx   = cand_q;
    div_nx    = div_q;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lim_nx   = limit;
          cand_nx  = WIDTH'(2);
          state_nx = CAND;
        end
      end
      CAND: begin
        if (cand_q > lim_q) begin
          state_nx = FIN;
        end else if (cand_q == WIDTH'(2) || cand_q == WIDTH'(3)) begin
          state_nx = EMIT;
        end else if (!cand_q[0]) begin
          cand_nx  = adv_cand;
          state_nx = adv_state;
        end else begin
          div_nx   = WIDTH'(3);
          state_nx = DIV_START;
        end
      end
      DIV_START: begin
        if (div_sq > (2*WIDTH)'(cand_q)) begin
          state_nx = EMIT;
        end else begin
          div_start = 1'b1;
          state_nx  = DIV_WAIT;
        end
      end
      DIV_WAIT: begin
        if (div_done) begin
          if (div_rem == '0) begin
            cand_nx  = adv_cand;
            state_nx = adv_state;
          end else begin
            div_nx   = div_q + WIDTH'(2);
            state_nx = DIV_START;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          cand_nx  = adv_cand;
          state_nx = adv_state;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nx  = IDLE;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lim_q     <= '0;
      cand_q    <= '0;
      div_q     <= '0;
      out_valid <= 1'b0;
      out_prime <= '0;
    end else begin
      state     <= state_nx;
      lim_q     <= lim_nx;
      cand_q    <= cand_nx;
      div_q     <= div_nx;
      out_valid <= (state_nx == EMIT);
      if (state_nx == EMIT && state != EMIT) out_prime <= cand_q;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule
